// File: rtl/mem_req_unit.sv
// Memory request unit: splits 8/16-bit core requests into byte cycles on an
// external byte bus, stalls the core while a transfer is in flight.
module mem_req_unit (
    input  logic        clk,
    input  logic        a_rst,
    input  logic        mar_wr,
    input  logic [15:0] mar_in,
    input  logic [15:0] wdata,
    input  logic        mem_rq,
    input  logic        mem_rq_cmd,
    input  logic        mem_rq_width,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_ready,
    output logic        stop,
    output logic [15:0] rdata,
    output logic        rdata_valid,
    output logic        done,
    output logic        bus_en,
    output logic        bus_we,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata
);

    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

    state_t      state;
    logic [15:0] mar;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_cmd;
    logic        req_width;

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state     <= IDLE;
            mar       <= 16'h0000;
            rdata     <= 16'h0000;
            req_addr  <= 16'h0000;
            req_wdata <= 16'h0000;
            req_cmd   <= 1'b0;
            req_width <= 1'b0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    if (mar_wr)
                        mar <= mar_in;
                    if (mem_rq) begin
                        // A same-cycle mar_wr forwards its address into the request.
                        req_addr  <= mar_wr ? mar_in : mar;
                        req_wdata <= wdata;
                        req_cmd   <= mem_rq_cmd;
                        req_width <= mem_rq_width;
                        state     <= LO;
                    end else begin
                        state <= IDLE;
                    end
                end
                LO: begin
                    if (bus_ready) begin
                        if (!req_cmd) begin
                            rdata[7:0] <= bus_rdata;
                            if (!req_width)
                                rdata[15:8] <= 8'h00;
                        end
                        state <= req_width ? HI : RESP;
                    end
                end
                HI: begin
                    if (bus_ready) begin
                        if (!req_cmd)
                            rdata[15:8] <= bus_rdata;
                        state <= RESP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // All outputs decode the state register only, so no input reaches them.
    always_comb begin
        stop        = (state == LO) || (state == HI);
        bus_en      = stop;
        bus_we      = stop && req_cmd;
        bus_addr    = (state == HI) ? req_addr + 16'd1 : req_addr;
        bus_wdata   = (state == HI) ? req_wdata[15:8] : req_wdata[7:0];
        done        = (state == RESP);
        rdata_valid = done && !req_cmd;
    end

endmodule

// File: tb/tb_mem_req_unit.sv
// Scoreboard bench for mem_req_unit: directed scenarios plus randomized traffic
// against a byte-memory reference model, checked by an independent monitor.
module tb_mem_req_unit;

    logic        clk, a_rst;
    logic        mar_wr, mem_rq, mem_rq_cmd, mem_rq_width, bus_ready;
    logic [15:0] mar_in, wdata;
    logic [7:0]  bus_rdata;
    logic        stop, rdata_valid, done, bus_en, bus_we;
    logic [15:0] rdata, bus_addr;
    logic [7:0]  bus_wdata;

    mem_req_unit dut (
        .clk(clk), .a_rst(a_rst), .mar_wr(mar_wr), .mar_in(mar_in), .wdata(wdata),
        .mem_rq(mem_rq), .mem_rq_cmd(mem_rq_cmd), .mem_rq_width(mem_rq_width),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready), .stop(stop), .rdata(rdata),
        .rdata_valid(rdata_valid), .done(done), .bus_en(bus_en), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata)
    );

    typedef struct packed { logic [15:0] addr; logic we; logic [7:0] data; } beat_t;
    typedef struct packed { logic rd; logic [15:0] rdata; } resp_t;

    beat_t       beat_q[$];
    resp_t       resp_q[$];
    logic [7:0]  bus_mem [0:65535];
    logic [7:0]  ref_mem [0:65535];
    int          tests, fails;
    logic [15:0] mar_m, last_rd;
    bit          noise, rand_rdy;
    logic        rdy_val;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus_rdata = bus_mem[bus_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: inputs change 1ns after the edge; while the unit is stalled,
    // optionally toss junk onto mem_rq/mar_wr, which must be ignored.
    task automatic tick();
        @(posedge clk);
        #1;
        bus_ready = rand_rdy ? (($urandom % 3) != 0) : rdy_val;
        mem_rq = 1'b0;
        mar_wr = 1'b0;
        if (noise && stop) begin
            mem_rq       = $urandom_range(0, 1);
            mar_wr       = $urandom_range(0, 1);
            mar_in       = 16'($urandom);
            mem_rq_cmd   = $urandom_range(0, 1);
            mem_rq_width = $urandom_range(0, 1);
            wdata        = 16'($urandom);
        end
    endtask

    task automatic wait_free();
        int n = 0;
        while (stop && n < 200) begin
            tick();
            n++;
        end
        chk("wait_free_timeout", {31'd0, stop}, 32'd0);
    endtask

    task automatic load_mar(input logic [15:0] a);
        wait_free();
        mar_wr = 1'b1;
        mar_in = a;
        mar_m  = a;
        tick();
    endtask

    // Issue one request and record what the bus and response must look like.
    task automatic issue(input logic c, input logic w, input logic dm,
                         input logic [15:0] a, input logic [15:0] wd);
        logic [15:0] ad, ad1;
        wait_free();
        ad  = dm ? a : mar_m;
        ad1 = ad + 16'd1;
        if (dm) mar_m = a;
        mar_wr = dm; mar_in = a; mem_rq = 1'b1;
        mem_rq_cmd = c; mem_rq_width = w; wdata = wd;
        beat_q.push_back('{addr: ad, we: c, data: wd[7:0]});
        if (w) beat_q.push_back('{addr: ad1, we: c, data: wd[15:8]});
        if (c) begin
            ref_mem[ad] = wd[7:0];
            if (w) ref_mem[ad1] = wd[15:8];
        end else begin
            last_rd = {w ? ref_mem[ad1] : 8'h00, ref_mem[ad]};
        end
        resp_q.push_back('{rd: !c, rdata: last_rd});
        tick();
    endtask

    // Monitor: also acts as the bus slave's write port, so it alone owns bus_mem.
    initial begin
        beat_t b;
        resp_t r;
        for (int i = 0; i < 65536; i++) bus_mem[i] = 8'(i * 37 + 11);
        bus_mem[16'h1234] = 8'hAB;
        bus_mem[16'h2000] = 8'h34;
        bus_mem[16'h2001] = 8'h12;
        forever begin
            @(negedge clk);
            if (a_rst) begin
                if (bus_en || stop) chk("stop_vs_bus_en", {31'd0, stop}, {31'd0, bus_en});
                if (bus_en && bus_ready) begin
                    if (beat_q.size() == 0) begin
                        chk("unexpected_beat", 32'd1, 32'd0);
                    end else begin
                        b = beat_q.pop_front();
                        chk("beat_addr", {16'd0, bus_addr}, {16'd0, b.addr});
                        chk("beat_we", {31'd0, bus_we}, {31'd0, b.we});
                        if (b.we) chk("beat_wdata", {24'd0, bus_wdata}, {24'd0, b.data});
                    end
                    if (bus_we) bus_mem[bus_addr] = bus_wdata;
                end
                if (done) begin
                    if (resp_q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        r = resp_q.pop_front();
                        chk("resp_rdata_valid", {31'd0, rdata_valid}, {31'd0, r.rd});
                        chk("resp_rdata", {16'd0, rdata}, {16'd0, r.rdata});
                    end
                end
            end
        end
    end

    initial begin
        int n;
        tests = 0; fails = 0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'(i * 37 + 11);
        ref_mem[16'h1234] = 8'hAB;
        ref_mem[16'h2000] = 8'h34;
        ref_mem[16'h2001] = 8'h12;
        mar_m = 16'h0000; last_rd = 16'h0000;
        noise = 0; rand_rdy = 0; rdy_val = 1'b1;
        a_rst = 1'b0; mar_wr = 0; mar_in = 0; wdata = 0; mem_rq = 0;
        mem_rq_cmd = 0; mem_rq_width = 0; bus_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_stop", {31'd0, stop}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rdata_valid", {31'd0, rdata_valid}, 32'd0);
        chk("rst_bus_en", {31'd0, bus_en}, 32'd0);
        chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
        chk("rst_rdata", {16'd0, rdata}, 32'd0);
        a_rst = 1'b1;
        tick();

        // Byte read at 0x1234
        load_mar(16'h1234);
        issue(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("br_stop", {31'd0, stop}, 32'd1);
        chk("br_addr", {16'd0, bus_addr}, 32'h1234);
        tick();
        chk("br_done_n2", {31'd0, done}, 32'd1);
        chk("br_valid_n2", {31'd0, rdata_valid}, 32'd1);
        chk("br_rdata", {16'd0, rdata}, 32'h00AB);
        chk("br_stop_off", {31'd0, stop}, 32'd0);

        // Word write at 0xFFFF wraps the high byte to 0x0000
        issue(1'b1, 1'b1, 1'b1, 16'hFFFF, 16'hBEEF);
        chk("ww_lo_addr", {16'd0, bus_addr}, 32'hFFFF);
        chk("ww_lo_data", {24'd0, bus_wdata}, 32'hEF);
        chk("ww_lo_we", {31'd0, bus_we}, 32'd1);
        tick();
        chk("ww_hi_addr", {16'd0, bus_addr}, 32'h0000);
        chk("ww_hi_data", {24'd0, bus_wdata}, 32'hBE);
        tick();
        chk("ww_done_n3", {31'd0, done}, 32'd1);
        chk("ww_valid", {31'd0, rdata_valid}, 32'd0);
        chk("ww_rdata_kept", {16'd0, rdata}, 32'h00AB);

        // Word read with bus wait states: LO completes at N+4, HI at N+7
        load_mar(16'h2000);
        rdy_val = 1'b0;
        issue(1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
        for (int i = 1; i <= 7; i++) begin
            chk("wr_stop_held", {31'd0, stop}, 32'd1);
            rdy_val = ((i + 1) == 4) || ((i + 1) == 7);
            tick();
        end
        chk("wr_done_n8", {31'd0, done}, 32'd1);
        chk("wr_rdata", {16'd0, rdata}, 32'h1234);
        rdy_val = 1'b1;

        // Same-cycle mar_wr forwarding, then back-to-back from RESP
        load_mar(16'h1000);
        issue(1'b0, 1'b0, 1'b1, 16'h4000, 16'h0);
        chk("fwd_addr", {16'd0, bus_addr}, 32'h4000);
        tick();
        chk("b2b_done", {31'd0, done}, 32'd1);
        issue(1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
        chk("b2b_lo_now", {31'd0, stop}, 32'd1);
        chk("mar_updated", {16'd0, bus_addr}, 32'h4000);
        tick(); tick();

        // Reset in HI abandons the transfer
        issue(1'b0, 1'b1, 1'b1, 16'h0100, 16'h0);
        rdy_val = 1'b0;
        tick();
        chk("hi_before_rst", {31'd0, stop}, 32'd1);
        #2 a_rst = 1'b0;
        #1;
        chk("rst_hi_stop", {31'd0, stop}, 32'd0);
        chk("rst_hi_bus_en", {31'd0, bus_en}, 32'd0);
        chk("rst_hi_done", {31'd0, done}, 32'd0);
        beat_q.delete(); resp_q.delete();
        mar_m = 16'h0000; last_rd = 16'h0000;
        tick();
        a_rst = 1'b1;
        rdy_val = 1'b1;
        tick();
        chk("post_rst_done", {31'd0, done}, 32'd0);
        chk("post_rst_rdata", {16'd0, rdata}, 32'd0);

        // Randomized traffic
        noise = 1; rand_rdy = 1;
        for (int k = 0; k < 300; k++) begin
            logic [15:0] a;
            a = ($urandom % 8 == 0) ? 16'hFFFF : 16'h00F8 + 16'($urandom % 12);
            case ($urandom % 6)
                0: load_mar(a);
                1: tick();
                default: issue($urandom_range(0, 1), $urandom_range(0, 1),
                               $urandom_range(0, 1), a, 16'($urandom));
            endcase
        end
        noise = 0;
        n = 0;
        while ((resp_q.size() != 0 || stop) && n < 1000) begin
            tick();
            n++;
        end
        tick();
        chk("drain_resp", resp_q.size(), 32'd0);
        chk("drain_beats", beat_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
